// File: rtl/icache_if.sv
// Fetch-side and refill-side signals of the instruction cache, bundled.
// The cache uses the slave modport; the fetch stage and memory side use master.
interface icache_if;
    logic        req;
    logic [31:0] pcf;
    logic        flush;
    logic [31:0] ri;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  req, pcf, flush, mem_ack, mem_rdata,
        output ri, stall, mem_req, mem_addr
    );

    modport master (
        output req, pcf, flush, mem_ack, mem_rdata,
        input  ri, stall, mem_req, mem_addr
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache: combinational hit path, one-beat-per-ack
// line refill on miss, NOP bubble on ri while stalled.
module icache #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic     clk,
    input  logic     reset,
    icache_if.slave  bus
);
    localparam int OB = $clog2(WORDS);
    localparam int IB = $clog2(LINES);
    localparam int TB = 30 - OB - IB;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t            state_q, state_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [TB-1:0]     miss_tag_q, miss_tag_d;
    logic [IB-1:0]     miss_index_q, miss_index_d;
    logic [OB-1:0]     beat_q, beat_d;
    logic              flush_pending_q, flush_pending_d;
    logic              mem_req_q, mem_req_d;
    logic [31:0]       mem_addr_q, mem_addr_d;

    logic [TB-1:0]     tag_mem  [LINES];
    logic [31:0]       data_mem [LINES*WORDS];

    logic [OB-1:0]     pc_offset;
    logic [IB-1:0]     pc_index;
    logic [TB-1:0]     pc_tag;
    logic              hit;
    logic              refill_ack;
    logic              last_beat;
    logic [31:0]       ri_c;
    logic              stall_c;
    logic              unused_pcf_bits;

    assign pc_offset       = bus.pcf[OB+1:2];
    assign pc_index        = bus.pcf[OB+IB+1:OB+2];
    assign pc_tag          = bus.pcf[31:OB+IB+2];
    assign unused_pcf_bits = ^bus.pcf[1:0];

    assign hit        = bus.req && valid_q[pc_index] && (tag_mem[pc_index] == pc_tag);
    assign refill_ack = (state_q == REFILL) && mem_req_q && bus.mem_ack;
    assign last_beat  = (beat_q == OB'(WORDS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            valid_q         <= '0;
            miss_tag_q      <= '0;
            miss_index_q    <= '0;
            beat_q          <= '0;
            flush_pending_q <= 1'b0;
            mem_req_q       <= 1'b0;
            mem_addr_q      <= '0;
        end else begin
            state_q         <= state_d;
            valid_q         <= valid_d;
            miss_tag_q      <= miss_tag_d;
            miss_index_q    <= miss_index_d;
            beat_q          <= beat_d;
            flush_pending_q <= flush_pending_d;
            mem_req_q       <= mem_req_d;
            mem_addr_q      <= mem_addr_d;
        end
    end

    // Line storage carries no reset; only the valid bits gate its use.
    always_ff @(posedge clk) begin
        if (refill_ack) begin
            data_mem[{miss_index_q, beat_q}] <= bus.mem_rdata;
            if (last_beat) begin
                tag_mem[miss_index_q] <= miss_tag_q;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        valid_d         = valid_q;
        miss_tag_d      = miss_tag_q;
        miss_index_d    = miss_index_q;
        beat_d          = beat_q;
        flush_pending_d = flush_pending_q;
        mem_req_d       = mem_req_q;
        mem_addr_d      = mem_addr_q;
        case (state_q)
            IDLE: begin
                if (bus.req && !hit) begin
                    state_d      = REFILL;
                    miss_tag_d   = pc_tag;
                    miss_index_d = pc_index;
                    beat_d       = '0;
                    mem_req_d    = 1'b1;
                    mem_addr_d   = {pc_tag, pc_index, {OB{1'b0}}, 2'b00};
                end
            end
            REFILL: begin
                if (bus.flush) begin
                    flush_pending_d = 1'b1;
                end
                if (refill_ack) begin
                    beat_d     = beat_q + 1'b1;
                    mem_addr_d = mem_addr_q + 32'd4;
                    if (last_beat) begin
                        state_d         = IDLE;
                        mem_req_d       = 1'b0;
                        beat_d          = '0;
                        flush_pending_d = 1'b0;
                        if (!flush_pending_q) begin
                            valid_d[miss_index_q] = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A flush landing on the final beat's edge also keeps the line invalid.
        if (bus.flush) begin
            valid_d = '0;
        end
    end

    always_comb begin
        ri_c    = NOP;
        stall_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    if (hit) begin
                        ri_c = data_mem[{pc_index, pc_offset}];
                    end else begin
                        stall_c = 1'b1;
                    end
                end
            end
            REFILL:  stall_c = 1'b1;
            default: stall_c = 1'b0;
        endcase
    end

    assign bus.ri       = ri_c;
    assign bus.stall    = stall_c;
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: expected beat addresses and fetched words are
// queued when a fetch is issued and checked as the cache produces them.
module tb_icache;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic reset;
    icache_if bus();

    icache #(.LINES(16), .WORDS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_ri_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
    endfunction

    // Drives one fetch until the cache delivers a word; n_refills line fills are expected.
    task automatic access(input logic [31:0] addr, input int n_refills,
                          input logic [15:0] ack_pat, input int pat_len,
                          input int flush_at, output int stalls);
        int rc;
        bit done;
        logic ack;
        logic [31:0] base;
        logic [31:0] got;
        base = {addr[31:4], 4'h0};
        for (int r = 0; r < n_refills; r++)
            for (int b = 0; b < 4; b++)
                exp_addr_q.push_back(base + 32'(4 * b));
        exp_ri_q.push_back(mem_word(addr));
        stalls = 0;
        rc = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            @(negedge clk);
            bus.req = 1'b1;
            bus.pcf = addr;
            if (bus.mem_req) ack = (rc < pat_len) ? ack_pat[rc] : 1'b1;
            else ack = 1'b1;
            bus.mem_ack   = ack;
            bus.mem_rdata = bus.mem_req ? mem_word(bus.mem_addr) : 32'hDEAD_BEEF;
            bus.flush     = bus.mem_req && (rc == flush_at);
            #1;
            if (bus.stall) begin
                stalls++;
                checks++;
                if (bus.ri !== NOP) begin
                    errors++;
                    $display("FAIL stall_nop pc=%h ri=%h expected %h", addr, bus.ri, NOP);
                end
                if (bus.mem_req) begin
                    checks++;
                    if (exp_addr_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_beat pc=%h mem_addr=%h expected no request", addr, bus.mem_addr);
                    end else begin
                        if (bus.mem_addr !== exp_addr_q[0]) begin
                            errors++;
                            $display("FAIL beat_addr pc=%h mem_addr=%h expected %h", addr, bus.mem_addr, exp_addr_q[0]);
                        end
                        if (ack) void'(exp_addr_q.pop_front());
                    end
                    rc++;
                end
            end else begin
                done = 1'b1;
                got = exp_ri_q.pop_front();
                checks++;
                if (bus.ri !== got) begin
                    errors++;
                    $display("FAIL hit_word pc=%h ri=%h expected %h", addr, bus.ri, got);
                end
                checks++;
                if (bus.mem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL hit_mem_req pc=%h mem_req=%b expected 0", addr, bus.mem_req);
                end
            end
        end
        bus.flush = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL timeout pc=%h stalls=%0d expected hit within 64 cycles", addr, stalls);
            exp_ri_q.delete();
        end
        checks++;
        if (exp_addr_q.size() != 0) begin
            errors++;
            $display("FAIL missing_beats pc=%h left=%0d expected 0", addr, exp_addr_q.size());
            exp_addr_q.delete();
        end
        $display("access pc=%h refills=%0d stalls=%0d ri=%h", addr, n_refills, stalls, bus.ri);
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.ri !== NOP) begin
            errors++;
            $display("FAIL reset_out stall=%b ri=%h expected 0 %h", bus.stall, bus.ri, NOP);
        end
        checks++;
        if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem mem_req=%b mem_addr=%h expected 0 0", bus.mem_req, bus.mem_addr);
        end
        reset = 1'b1;
        $display("reset stall=%b ri=%h mem_req=%b", bus.stall, bus.ri, bus.mem_req);
    endtask

    task automatic test_cold_miss();
        int s;
        access(32'h40, 1, 16'hFFFF, 0, -1, s);
        checks++;
        if (s != 5) begin
            errors++;
            $display("FAIL cold_miss_stalls got=%0d expected 5", s);
        end
    endtask

    task automatic test_spatial_hit();
        int s;
        for (int i = 1; i < 4; i++) begin
            access(32'h40 + 32'(4 * i), 0, 16'hFFFF, 0, -1, s);
            checks++;
            if (s != 0) begin
                errors++;
                $display("FAIL spatial_stalls pc=%h got=%0d expected 0", 32'h40 + 32'(4 * i), s);
            end
        end
    endtask

    task automatic test_ack_gaps();
        int s;
        access(32'h80, 1, 16'b101_1001, 7, -1, s);
        checks++;
        if (s != 8) begin
            errors++;
            $display("FAIL ack_gap_stalls got=%0d expected 8", s);
        end
    endtask

    task automatic test_conflict();
        int s;
        logic [31:0] seq [3];
        seq[0] = 32'h000;
        seq[1] = 32'h100;
        seq[2] = 32'h000;
        for (int i = 0; i < 3; i++) begin
            access(seq[i], 1, 16'hFFFF, 0, -1, s);
            checks++;
            if (s != 5) begin
                errors++;
                $display("FAIL conflict_stalls pc=%h got=%0d expected 5", seq[i], s);
            end
        end
    endtask

    task automatic test_flush();
        int s;
        access(32'h40, 0, 16'hFFFF, 0, -1, s);
        // Same-cycle lookup must still see the line before the flush takes effect.
        @(negedge clk);
        bus.req   = 1'b1;
        bus.pcf   = 32'h4C;
        bus.flush = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.ri !== mem_word(32'h4C)) begin
            errors++;
            $display("FAIL flush_same_cycle stall=%b ri=%h expected 0 %h", bus.stall, bus.ri, mem_word(32'h4C));
        end
        $display("flush idle pc=%h stall=%b ri=%h", bus.pcf, bus.stall, bus.ri);
        @(negedge clk);
        bus.flush = 1'b0;
        bus.req   = 1'b0;
        access(32'h40, 1, 16'hFFFF, 0, -1, s);
        checks++;
        if (s != 5) begin
            errors++;
            $display("FAIL flush_idle_stalls got=%0d expected 5", s);
        end
        access(32'h80, 1, 16'hFFFF, 0, -1, s);
        checks++;
        if (s != 5) begin
            errors++;
            $display("FAIL flush_80_stalls got=%0d expected 5", s);
        end
        // Flush during beat 2: the first fill drains but stays invalid, so a second fill follows.
        @(negedge clk);
        bus.req   = 1'b0;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        access(32'h80, 2, 16'hFFFF, 0, 2, s);
        checks++;
        if (s != 10) begin
            errors++;
            $display("FAIL flush_refill_stalls got=%0d expected 10", s);
        end
    endtask

    task automatic test_reset_mid_refill();
        int s;
        @(negedge clk);
        bus.req     = 1'b1;
        bus.pcf     = 32'hC0;
        bus.mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.mem_rdata = mem_word(bus.mem_addr);
        end
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'hC8) begin
            errors++;
            $display("FAIL pre_reset_beat mem_req=%b mem_addr=%h expected 1 000000c8", bus.mem_req, bus.mem_addr);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_abort mem_req=%b mem_addr=%h expected 0 0", bus.mem_req, bus.mem_addr);
        end
        $display("reset mid-refill mem_req=%b mem_addr=%h", bus.mem_req, bus.mem_addr);
        bus.req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        access(32'hC4, 1, 16'hFFFF, 0, -1, s);
        checks++;
        if (s != 5) begin
            errors++;
            $display("FAIL post_reset_stalls got=%0d expected 5", s);
        end
    endtask

    initial begin
        reset         = 1'b0;
        bus.req       = 1'b0;
        bus.pcf       = '0;
        bus.flush     = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        test_reset();
        test_cold_miss();
        test_spatial_hit();
        test_ack_gaps();
        test_conflict();
        test_flush();
        test_reset_mid_refill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/icache.md
# icache

Direct-mapped instruction cache sitting between the fetch-stage PC (`pcf`) and the instruction register that latches `ri`. It returns the instruction word for `pcf` combinationally on a hit. On a miss it raises `stall` and refills one line from instruction memory over a beat-per-ack handshake. While stalled, `ri` carries a NOP so the fetch/decode register captures a bubble.

## Interface
- `LINES`, 16, number of cache lines; power of two, ≥2
- `WORDS`, 4, 32-bit words per line; power of two, ≥2

- `clk` in 1 — processor clock, all state updates on rising edge
- `reset` in 1 — asynchronous, active-low; one clock domain only
- `req` in 1 — fetch request valid for `pcf`
- `pcf` in 32 — fetch byte address; bits [1:0] ignored
- `flush` in 1 — invalidate all lines (single-cycle pulse)
- `ri` out 32 — instruction word
- `stall` out 1 — fetch must hold `pcf`; `ri` is not valid
- `mem_req` out 1 — refill beat request
- `mem_addr` out 32 — word-aligned address of the requested beat
- `mem_ack` in 1 — `mem_rdata` valid for the current beat
- `mem_rdata` in 32 — refill data

## Operation
- Address split (OB = log2 WORDS, IB = log2 LINES):
  - word offset = `pcf[OB+1:2]`
  - index = `pcf[OB+IB+1:OB+2]`
  - tag = remaining upper bits
- Storage:
  - per line: valid bit, tag, WORDS data words
  - data is not reset; only valid bits are cleared
- States: IDLE, REFILL.
- IDLE:
  - Hit (`req` & valid & tag match): `ri` = stored word, `stall`=0.
  - Miss (`req` & !hit): `stall`=1 combinationally and `ri`=32'h00000013. Miss tag and index are latched, beat counter set to 0, and the FSM moves to REFILL on the next edge.
  - `req`=0: `stall`=0, `ri`=32'h00000013, no state change.
- REFILL:
  - `mem_req`=1 and `mem_addr`={miss tag, miss index, beat, 2'b00}; `stall`=1; `ri`=NOP.
  - Each edge with `mem_ack`=1 writes `mem_rdata` into word[beat] of the miss line and increments beat.
  - On the ack of beat WORDS-1, the tag is written, valid is set, and the FSM goes to IDLE.
  - `mem_ack` while `mem_req`=0 is ignored.
- Refill always targets the latched miss address. If `pcf` changes during REFILL, the line still completes, and lookup restarts in IDLE with the new `pcf`.
- Flush:
  - In IDLE, `flush` clears all valid bits at the edge. The same-cycle lookup still uses the pre-flush valid bits.
  - In REFILL, `flush` clears all valid bits and sets a `flush_pending` flag. The refill runs to completion so all memory beats are drained, but the line is not marked valid; `flush_pending` clears on the return to IDLE.
- Conflict: a refill overwrites the tag and data of the indexed line, and the previous contents are lost.

## Timing
- Reset (`reset`=0, asynchronous):
  - state IDLE, all valid bits 0, beat 0, `flush_pending` 0, `mem_req`=0, `mem_addr`=0
  - `ri`=NOP and `stall`=0 while `req`=0
  - `reset` falling mid-REFILL aborts the refill immediately; the partial line stays invalid.
- Hit latency: 0 cycles, combinational from `pcf`.
- Miss timeline with `mem_ack` held high:
  - cycle 0: miss detected
  - cycles 1..WORDS: REFILL beats
  - cycle WORDS+1: hit with `stall`=0
  - Miss penalty = WORDS+1 cycles, plus one cycle per ack-low cycle.
- `mem_req` and `mem_addr` are registered and hold stable until acknowledged; `mem_addr` advances by 4 the cycle after each ack.
- `stall` is high for every cycle from miss detection through the last REFILL cycle inclusive.

## Test plan
- Cold miss, default params, `mem_ack` held high:
  - `req`=1, `pcf`=0x40 after reset → `stall`=1 for 5 cycles.
  - `mem_addr` sequence 0x40, 0x44, 0x48, 0x4C.
  - Cycle 5: `ri`=memory word at 0x40, `stall`=0.
- Spatial hit: after the refill above, `pcf`=0x44, 0x48, 0x4C on consecutive cycles → the three stored words with `stall`=0 and `mem_req`=0 throughout.
- Ack gaps: miss on 0x80 with `mem_ack` pattern 1,0,0,1,1,0,1 → four beats written in order, `stall`=1 for 8 cycles, then hit; `mem_addr` holds steady during ack-low cycles.
- Conflict eviction:
  - Fill 0x000, then access 0x100 (same index 0, different tag) → refill.
  - Re-access 0x000 → miss again and refill from `mem_addr`=0x000.
- Flush:
  - Fill 0x40, pulse `flush` in IDLE, re-access 0x40 → miss.
  - Pulse `flush` during the beat-2 refill of 0x80 → refill drains all 4 beats, then 0x80 misses again.
- Reset mid-refill: drive `reset`=0 after beat 1 → `mem_req`=0 immediately. After release, an access to the same address misses and refills from beat 0.
